instr_mem_writer: RTL and testbench

Sequential instruction encoder and loader for the MIPS processor. It accepts instruction requests as separate fields (kind, registers, shamt, funct, immediate) over a valid/ready handshake. Each request is packed into a 32-bit MIPS word using the opcodes the control unit decodes (R-type 0x00, ADDI 0x08, ORI 0x0D, LUI 0x0F). Words are written sequentially into instruction memory through a write port with acknowledge. The block sits beside instruction memory and preloads test programs before the core is released from reset.

---
 rtl/instr_mem_writer_if.sv | 38 +++
 rtl/instr_mem_writer.sv | 109 ++++++++++
 tb/tb_instr_mem_writer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_writer_if.sv
// Request fields plus instruction-memory write port for the program loader.
// Latency: none, wires only.
// Backpressure: req_ready_o gates requests; mem_ack_i holds a write in place.
interface instr_mem_writer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic [1:0]            req_kind_i;
    logic [4:0]            rs_i;
    logic [4:0]            rt_i;
    logic [4:0]            rd_i;
    logic [4:0]            shamt_i;
    logic [5:0]            funct_i;
    logic [15:0]           imm_i;
    logic                  last_i;
    logic                  mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic                  mem_ack_i;

    // Loader view: takes requests, drives the memory write port.
    modport slave (
        input  req_valid_i, req_kind_i, rs_i, rt_i, rd_i, shamt_i, funct_i, imm_i, last_i,
        output req_ready_o,
        output mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_ack_i
    );

    // Environment view: issues requests and acknowledges memory writes.
    modport master (
        output req_valid_i, req_kind_i, rs_i, rt_i, rd_i, shamt_i, funct_i, imm_i, last_i,
        input  req_ready_o,
        input  mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_ack_i
    );
endinterface

// File: rtl/instr_mem_writer.sv
// Encodes MIPS instruction requests and writes them sequentially into instruction memory.
// Latency: start -> ready next cycle; handshake -> write strobe next cycle; ack -> next word or done.
// Backpressure: one request in flight; ready stays low until the current write is acknowledged.
module instr_mem_writer #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 32,
    parameter logic [31:0] BASE_ADDR  = 32'h0040_0000,
    parameter int          MAX_WORDS  = 64
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                start_i,
    instr_mem_writer_if.slave   bus,
    output logic                busy_o,
    output logic                done_o,
    output logic                overflow_o,
    output logic [15:0]         word_count_o
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_WRITE  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t      state;
    logic        last_q;
    logic [31:0] enc_word;
    logic [15:0] count_nxt;

    assign count_nxt = word_count_o + 16'd1;

    // Pack the presented fields into a MIPS word; LUI has no rs, I-types drop rd/shamt/funct.
    always_comb begin
        enc_word = 32'h0;
        case (bus.req_kind_i)
            2'd0:    enc_word = {OP_RTYPE, bus.rs_i, bus.rt_i, bus.rd_i, bus.shamt_i, bus.funct_i};
            2'd1:    enc_word = {OP_ADDI, bus.rs_i, bus.rt_i, bus.imm_i};
            2'd2:    enc_word = {OP_ORI, bus.rs_i, bus.rt_i, bus.imm_i};
            default: enc_word = {OP_LUI, 5'b0, bus.rt_i, bus.imm_i};
        endcase
    end

    // Session FSM with all outputs registered; address and count hold after DONE until next start.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state           <= ST_IDLE;
            last_q          <= 1'b0;
            bus.req_ready_o <= 1'b0;
            bus.mem_we_o    <= 1'b0;
            bus.mem_addr_o  <= ADDR_WIDTH'(BASE_ADDR);
            bus.mem_wdata_o <= '0;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
            overflow_o      <= 1'b0;
            word_count_o    <= 16'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        state           <= ST_ACCEPT;
                        bus.mem_addr_o  <= ADDR_WIDTH'(BASE_ADDR);
                        word_count_o    <= 16'd0;
                        overflow_o      <= 1'b0;
                        bus.req_ready_o <= 1'b1;
                        busy_o          <= 1'b1;
                    end
                end
                ST_ACCEPT: begin
                    if (bus.req_valid_i) begin
                        state           <= ST_WRITE;
                        bus.mem_wdata_o <= DATA_WIDTH'(enc_word);
                        last_q          <= bus.last_i;
                        bus.req_ready_o <= 1'b0;
                        bus.mem_we_o    <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (bus.mem_ack_i) begin
                        bus.mem_we_o   <= 1'b0;
                        bus.mem_addr_o <= bus.mem_addr_o + ADDR_WIDTH'(4);
                        word_count_o   <= count_nxt;
                        if (last_q) begin
                            state  <= ST_DONE;
                            done_o <= 1'b1;
                        end else if (count_nxt == 16'(MAX_WORDS)) begin
                            state      <= ST_DONE;
                            done_o     <= 1'b1;
                            overflow_o <= 1'b1;
                        end else begin
                            state           <= ST_ACCEPT;
                            bus.req_ready_o <= 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instr_mem_writer.sv
// Scoreboard bench for the instruction loader: expected writes queued at request time.
// Latency: memory responder acks after a programmable number of strobe cycles.
// Backpressure: ack delay is varied to hold writes in place.
module tb_instr_mem_writer;
    localparam int          MAXW = 4;
    localparam logic [31:0] BASE = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [15:0] wcount;

    always #5 clk = ~clk;

    instr_mem_writer_if bus ();

    instr_mem_writer #(
        .MAX_WORDS (MAXW)
    ) dut (
        .clk_i        (clk),
        .reset_i      (rst),
        .start_i      (start),
        .bus          (bus),
        .busy_o       (busy),
        .done_o       (done),
        .overflow_o   (ovf),
        .word_count_o (wcount)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    logic [63:0] sb[$];
    logic [63:0] sb_head;
    int ack_delay   = 0;
    int wait_cnt    = 0;
    int writes_seen = 0;
    int done_cnt    = 0;
    logic done_prev = 1'b0;

    // Memory responder: checks every strobed cycle against the queue head, acks after ack_delay waits.
    always @(negedge clk) begin
        bus.mem_ack_i = 1'b0;
        if (rst || !bus.mem_we_o) begin
            wait_cnt = 0;
        end else if (sb.size() == 0) begin
            check_eq("unexpected_write", sb.size(), 1);
        end else begin
            sb_head = sb[0];
            check_eq("wr_addr", bus.mem_addr_o, sb_head[63:32]);
            check_eq("wr_data", bus.mem_wdata_o, sb_head[31:0]);
            check_eq("ready_in_write", bus.req_ready_o, 0);
            if (wait_cnt >= ack_delay) begin
                bus.mem_ack_i = 1'b1;
                void'(sb.pop_front());
                writes_seen++;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end
        if (!rst && done) begin
            done_cnt++;
            check_eq("busy_with_done", busy, 1);
            check_eq("done_one_cycle", done_prev, 0);
        end
        done_prev = done;
    end

    task automatic start_session();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("ready_after_start", bus.req_ready_o, 1);
        check_eq("busy_after_start", busy, 1);
        check_eq("count_cleared", wcount, 0);
        check_eq("ovf_cleared", ovf, 0);
        check_eq("addr_base", bus.mem_addr_o, BASE);
    endtask

    task automatic send_req(input logic [1:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                            input logic [15:0] imm, input logic last, input logic [31:0] exp_addr,
                            input logic [31:0] exp_data, input logic exp_acc);
        int   n;
        logic acc;
        n = 0;
        bus.req_kind_i = kind;
        bus.rs_i       = rs;
        bus.rt_i       = rt;
        bus.rd_i       = rd;
        bus.shamt_i    = sh;
        bus.funct_i    = fn;
        bus.imm_i      = imm;
        bus.last_i     = last;
        sb.push_back({exp_addr, exp_data});
        bus.req_valid_i = 1'b1;
        while (!bus.req_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        acc = bus.req_ready_o;
        if (acc) @(negedge clk);
        else void'(sb.pop_back());
        bus.req_valid_i = 1'b0;
        check_eq("accepted", acc, exp_acc);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("idle_reached", busy, 0);
    endtask

    task automatic end_check(input int d0, input int w0, input int exp_words,
                             input logic exp_ovf, input logic [31:0] exp_addr);
        check_eq("word_count", wcount, exp_words);
        check_eq("overflow", ovf, exp_ovf);
        check_eq("final_addr", bus.mem_addr_o, exp_addr);
        check_eq("done_pulses", done_cnt - d0, 1);
        check_eq("writes_seen", writes_seen - w0, exp_words);
        check_eq("sb_drained", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, w0, n;
        bus.req_valid_i = 1'b0;
        bus.req_kind_i  = 2'd0;
        bus.rs_i        = 5'd0;
        bus.rt_i        = 5'd0;
        bus.rd_i        = 5'd0;
        bus.shamt_i     = 5'd0;
        bus.funct_i     = 6'd0;
        bus.imm_i       = 16'd0;
        bus.last_i      = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("rst_ready", bus.req_ready_o, 0);
        check_eq("rst_we", bus.mem_we_o, 0);
        check_eq("rst_addr", bus.mem_addr_o, BASE);
        check_eq("rst_wdata", bus.mem_wdata_o, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_ovf", ovf, 0);
        check_eq("rst_count", wcount, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single R-type word, immediate ack.
        d0 = done_cnt; w0 = writes_seen;
        start_session();
        send_req(2'd0, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 16'h0, 1'b1, BASE, 32'h012A_4020, 1'b1);
        wait_idle();
        end_check(d0, w0, 1, 1'b0, BASE + 32'd4);

        // ADDI, ORI, LUI (rs ignored on LUI).
        d0 = done_cnt; w0 = writes_seen;
        start_session();
        send_req(2'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0005, 1'b0, BASE, 32'h2008_0005, 1'b1);
        send_req(2'd2, 5'd8, 5'd9, 5'd0, 5'd0, 6'h0, 16'h00FF, 1'b0, BASE + 32'd4, 32'h3509_00FF, 1'b1);
        send_req(2'd3, 5'd31, 5'd1, 5'd7, 5'd3, 6'h3F, 16'h1001, 1'b1, BASE + 32'd8, 32'h3C01_1001, 1'b1);
        wait_idle();
        end_check(d0, w0, 3, 1'b0, BASE + 32'd12);

        // Held write: ack after 5 wait cycles, strobe high for 6 cycles.
        ack_delay = 5;
        d0 = done_cnt; w0 = writes_seen;
        start_session();
        send_req(2'd0, 5'd1, 5'd2, 5'd3, 5'd4, 6'h2A, 16'h0, 1'b1, BASE, 32'h0022_192A, 1'b1);
        n = 0;
        while (bus.mem_we_o && n < 50) begin
            n++;
            @(negedge clk);
        end
        check_eq("we_hold_cycles", n, 6);
        wait_idle();
        end_check(d0, w0, 1, 1'b0, BASE + 32'd4);
        ack_delay = 0;

        // Six requests without last: only MAXW written, overflow sticky.
        d0 = done_cnt; w0 = writes_seen;
        start_session();
        for (int i = 0; i < 6; i++) begin
            send_req(2'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'(i), 1'b0,
                     BASE + 32'(4 * i), 32'h2022_0000 + 32'(i), 1'(i < MAXW));
        end
        wait_idle();
        end_check(d0, w0, MAXW, 1'b1, BASE + 32'(4 * MAXW));
        repeat (3) @(negedge clk);
        check_eq("ovf_sticky", ovf, 1);

        // Last on the MAXW-th word ends normally.
        d0 = done_cnt; w0 = writes_seen;
        start_session();
        for (int i = 0; i < MAXW; i++) begin
            send_req(2'd2, 5'd3, 5'd4, 5'd0, 5'd0, 6'h0, 16'h0100 + 16'(i), 1'(i == MAXW - 1),
                     BASE + 32'(4 * i), 32'h3464_0100 + 32'(i), 1'b1);
        end
        wait_idle();
        end_check(d0, w0, MAXW, 1'b0, BASE + 32'(4 * MAXW));

        // Reset while a write is pending.
        ack_delay = 1000;
        start_session();
        send_req(2'd1, 5'd5, 5'd6, 5'd0, 5'd0, 6'h0, 16'hBEEF, 1'b1, BASE, 32'h20A6_BEEF, 1'b1);
        repeat (2) @(negedge clk);
        check_eq("we_before_reset", bus.mem_we_o, 1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("mrst_we", bus.mem_we_o, 0);
        check_eq("mrst_busy", busy, 0);
        check_eq("mrst_count", wcount, 0);
        check_eq("mrst_addr", bus.mem_addr_o, BASE);
        check_eq("mrst_ready", bus.req_ready_o, 0);
        rst = 1'b0;
        sb.delete();
        ack_delay = 0;
        @(negedge clk);
        d0 = done_cnt; w0 = writes_seen;
        start_session();
        send_req(2'd3, 5'd0, 5'd2, 5'd0, 5'd0, 6'h0, 16'h8000, 1'b1, BASE, 32'h3C02_8000, 1'b1);
        wait_idle();
        end_check(d0, w0, 1, 1'b0, BASE + 32'd4);

        // start held through ACCEPT and WRITE must not restart the session.
        ack_delay = 2;
        d0 = done_cnt; w0 = writes_seen;
        start_session();
        start = 1'b1;
        @(negedge clk);
        check_eq("start_in_accept_ready", bus.req_ready_o, 1);
        send_req(2'd1, 5'd0, 5'd3, 5'd0, 5'd0, 6'h0, 16'h0011, 1'b0, BASE, 32'h2003_0011, 1'b1);
        n = 0;
        while (!bus.req_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check_eq("back_to_accept", bus.req_ready_o, 1);
        check_eq("count_kept", wcount, 1);
        check_eq("addr_kept", bus.mem_addr_o, BASE + 32'd4);
        send_req(2'd2, 5'd3, 5'd3, 5'd0, 5'd0, 6'h0, 16'h0022, 1'b1, BASE + 32'd4, 32'h3463_0022, 1'b1);
        wait_idle();
        end_check(d0, w0, 2, 1'b0, BASE + 32'd8);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
